// File: rtl/data_mem_responder.sv
// Memory-side responder for the core req/gnt/rvalid data interface: a word-addressed
// local RAM with programmable grant wait states, response latency and outstanding depth.
module data_mem_responder #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    MEM_WORDS       = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h0010_0000,
    parameter int                    GNT_WAIT        = 0,
    parameter int                    RESP_LATENCY    = 1,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o
);

    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int IDX_W   = $clog2(MEM_WORDS);
    localparam int TAG_LSB = IDX_W + 2;

    localparam logic [3:0] GNT_WAIT_C = 4'(GNT_WAIT);
    localparam logic [2:0] MAX_OUTST  = 3'(MAX_OUTSTANDING);

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    logic [3:0] wait_q, wait_d;
    logic [2:0] outst_q, outst_d;
    resp_t      pipe_q [RESP_LATENCY];
    resp_t      pipe_d [RESP_LATENCY];

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic             hs;
    logic             hit;
    logic             wr_en;
    logic [IDX_W-1:0] idx;
    logic             unused_addr_lsbs;

    // BASE_ADDR is aligned to the RAM size, so a tag compare is the full range check
    // and addresses past the last word never alias back onto word 0.
    assign hit              = addr_i[ADDR_WIDTH-1:TAG_LSB] == BASE_ADDR[ADDR_WIDTH-1:TAG_LSB];
    assign idx              = addr_i[TAG_LSB-1:2];
    assign unused_addr_lsbs = ^addr_i[1:0];

    // A full outstanding window still grants when a response retires on the same edge.
    assign gnt_o = req_i & ~reset & (wait_q == GNT_WAIT_C)
                 & ((outst_q < MAX_OUTST) | rvalid_o);
    assign hs    = req_i & gnt_o;
    assign wr_en = hs & we_i & hit;

    assign rvalid_o = pipe_q[RESP_LATENCY-1].valid;
    assign err_o    = pipe_q[RESP_LATENCY-1].err;
    assign rdata_o  = pipe_q[RESP_LATENCY-1].data;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        wait_d = wait_q;
        if (!req_i || hs) begin
            wait_d = '0;
        end else if (wait_q != GNT_WAIT_C) begin
            wait_d = wait_q + 4'd1;
        end

        outst_d = outst_q + {2'b00, hs} - {2'b00, rvalid_o};

        for (int i = 0; i < RESP_LATENCY; i++) begin
            if (i == 0) begin
                pipe_d[i].valid = hs;
                pipe_d[i].err   = hs & ~hit;
                pipe_d[i].data  = (hs && hit && !we_i) ? mem[idx] : '0;
            end else begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            wait_q  <= '0;
            outst_q <= '0;
            for (int i = 0; i < RESP_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            wait_q  <= wait_d;
            outst_q <= outst_d;
            for (int i = 0; i < RESP_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // NOTE: the RAM array has no reset; clearing it would force it out of RAM macros
    // into flops, and its contents are defined only by writes.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances cover zero-wait/latency-1,
// grant wait states, and a deep response pipeline with a limited outstanding window.
module tb_data_mem_responder;

    localparam logic [31:0] BASE = 32'h0010_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_req = 1'b0, a_we = 1'b0, a_gnt, a_rvalid, a_err;
    logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
    logic [3:0]  a_be = '0;

    logic        w_req = 1'b0, w_we = 1'b1, w_gnt, w_rvalid, w_err;
    logic [31:0] w_addr = 32'h0010_0010, w_wdata = 32'h5A5A_5A5A, w_rdata;
    logic [3:0]  w_be = 4'hF;

    logic        l_req = 1'b0, l_we = 1'b0, l_gnt, l_rvalid, l_err;
    logic [31:0] l_addr = '0, l_wdata = '0, l_rdata;
    logic [3:0]  l_be = '0;

    int w_req_tab [12] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int w_gnt_tab [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    int w_rv_tab  [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    int l_gnt_tab [9]  = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
    int l_rv_tab  [9]  = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
    logic [31:0] l_data [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

    data_mem_responder #(.GNT_WAIT(0), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
        .clock(clk), .reset(rst), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr),
        .we_i(a_we), .be_i(a_be), .wdata_i(a_wdata), .rvalid_o(a_rvalid),
        .rdata_o(a_rdata), .err_o(a_err)
    );

    data_mem_responder #(.GNT_WAIT(3), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u_w (
        .clock(clk), .reset(rst), .req_i(w_req), .gnt_o(w_gnt), .addr_i(w_addr),
        .we_i(w_we), .be_i(w_be), .wdata_i(w_wdata), .rvalid_o(w_rvalid),
        .rdata_o(w_rdata), .err_o(w_err)
    );

    data_mem_responder #(.GNT_WAIT(0), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u_l (
        .clock(clk), .reset(rst), .req_i(l_req), .gnt_o(l_gnt), .addr_i(l_addr),
        .we_i(l_we), .be_i(l_be), .wdata_i(l_wdata), .rvalid_o(l_rvalid),
        .rdata_o(l_rdata), .err_o(l_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One isolated transaction on the latency-1 instance: immediate grant, response next cycle.
    task automatic a_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        a_req = 1'b1; a_we = we; a_addr = addr; a_be = be; a_wdata = wd;
        #1;
        check({tag, "_gnt"}, 32'(a_gnt), 32'd1);
        @(negedge clk);
        a_req = 1'b0; a_we = 1'b0;
        #1;
        check({tag, "_rvalid"}, 32'(a_rvalid), 32'd1);
        check({tag, "_err"}, 32'(a_err), 32'(exp_err));
        check({tag, "_rdata"}, a_rdata, exp_rd);
    endtask

    task automatic l_write(input int k);
        @(negedge clk);
        l_req = 1'b1; l_we = 1'b1; l_addr = BASE + 32'h40 + 32'(4 * k);
        l_be = 4'hF; l_wdata = l_data[k];
        #1;
        check("l_wr_gnt", 32'(l_gnt), 32'd1);
        @(negedge clk);
        l_req = 1'b0; l_we = 1'b0;
        #1;
        check("l_wr_rv_early", 32'(l_rvalid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("l_wr_rv", 32'(l_rvalid), 32'd1);
        check("l_wr_err", 32'(l_err), 32'd0);
    endtask

    initial begin
        int k;
        int n;
        int seen;

        // Reset state, with a request already pending on the zero-wait instance.
        #1 rst = 1'b1;
        a_req = 1'b1; a_addr = BASE;
        #1;
        check("rst_gnt", 32'(a_gnt), 32'd0);
        check("rst_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Write then read back-to-back: the read sees the word written the edge before.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = BASE; a_be = 4'hF; a_wdata = 32'hDEAD_BEEF;
        #1;
        check("t1_wr_gnt", 32'(a_gnt), 32'd1);
        check("t1_wr_rv0", 32'(a_rvalid), 32'd0);
        @(negedge clk);
        a_we = 1'b0;
        #1;
        check("t1_rd_gnt", 32'(a_gnt), 32'd1);
        check("t1_wr_rv", 32'(a_rvalid), 32'd1);
        check("t1_wr_err", 32'(a_err), 32'd0);
        check("t1_wr_rdata", a_rdata, 32'd0);
        @(negedge clk);
        a_req = 1'b0;
        #1;
        check("t1_rd_rv", 32'(a_rvalid), 32'd1);
        check("t1_rd_err", 32'(a_err), 32'd0);
        check("t1_rd_rdata", a_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        check("t1_idle_rv", 32'(a_rvalid), 32'd0);

        // Byte enables, including an all-zero mask.
        a_txn("t2_wr_full", 1'b1, BASE + 32'h4, 4'hF, 32'h1122_3344, 32'd0, 1'b0);
        a_txn("t2_wr_part", 1'b1, BASE + 32'h4, 4'b0101, 32'hAABB_CCDD, 32'd0, 1'b0);
        a_txn("t2_rd", 1'b0, BASE + 32'h4, 4'h0, 32'd0, 32'h11BB_33DD, 1'b0);
        a_txn("t2_wr_be0", 1'b1, BASE + 32'h4, 4'h0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        a_txn("t2_rd_be0", 1'b0, BASE + 32'h4, 4'h0, 32'd0, 32'h11BB_33DD, 1'b0);

        // Decode boundaries: last word hits, one past it and one below base miss.
        a_txn("t5_wr_last", 1'b1, BASE + 32'hFFC, 4'hF, 32'hCAFE_F00D, 32'd0, 1'b0);
        a_txn("t5_rd_last", 1'b0, BASE + 32'hFFC, 4'h0, 32'd0, 32'hCAFE_F00D, 1'b0);
        a_txn("t5_rd_miss", 1'b0, BASE + 32'h1000, 4'h0, 32'd0, 32'd0, 1'b1);
        a_txn("t5_wr_miss", 1'b1, BASE + 32'h1000, 4'hF, 32'h1234_5678, 32'd0, 1'b1);
        a_txn("t5_rd_word0", 1'b0, BASE, 4'h0, 32'd0, 32'hDEAD_BEEF, 1'b0);
        a_txn("t5_rd_below", 1'b0, BASE - 32'h4, 4'h0, 32'd0, 32'd0, 1'b1);

        // Grant wait states: count restarts after req drops, and again after a handshake.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            w_req = w_req_tab[c][0];
            #1;
            check($sformatf("t3_gnt%0d", c), 32'(w_gnt), 32'(w_gnt_tab[c]));
            check($sformatf("t3_rv%0d", c), 32'(w_rvalid), 32'(w_rv_tab[c]));
        end

        // Latency-3 instance: preload four words, then a held burst of four reads.
        for (int i = 0; i < 4; i++) begin
            l_write(i);
        end
        k = 0;
        n = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            l_req = (k < 4);
            l_we = 1'b0;
            l_addr = BASE + 32'h40 + 32'(4 * k);
            #1;
            check($sformatf("t4_gnt%0d", c), 32'(l_gnt), 32'(l_gnt_tab[c]));
            check($sformatf("t4_rv%0d", c), 32'(l_rvalid), 32'(l_rv_tab[c]));
            if (l_rvalid) begin
                check($sformatf("t4_rdata%0d", n), l_rdata, l_data[n & 3]);
                n++;
            end
            if (l_req && l_gnt) k++;
        end
        check("t4_resp_count", 32'(n), 32'd4);

        // Reset with responses in flight discards them; the next request proceeds normally.
        @(negedge clk);
        l_req = 1'b1; l_addr = BASE + 32'h40;
        #1;
        check("t6_gnt0", 32'(l_gnt), 32'd1);
        @(negedge clk);
        l_addr = BASE + 32'h44;
        #1;
        check("t6_gnt1", 32'(l_gnt), 32'd1);
        @(negedge clk);
        l_addr = BASE + 32'h48;
        #1;
        check("t6_full_gnt", 32'(l_gnt), 32'd0);
        @(negedge clk);
        #1;
        check("t6_rv_before", 32'(l_rvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_gnt", 32'(l_gnt), 32'd0);
        check("t6_rst_rv", 32'(l_rvalid), 32'd0);
        check("t6_rst_rdata", l_rdata, 32'd0);
        check("t6_rst_err", 32'(l_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        l_req = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (l_rvalid) seen++;
        end
        check("t6_no_stale_rv", 32'(seen), 32'd0);
        @(negedge clk);
        l_req = 1'b1; l_addr = BASE + 32'h48;
        #1;
        check("t6_regnt", 32'(l_gnt), 32'd1);
        @(negedge clk);
        l_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t6_re_rv", 32'(l_rvalid), 32'd1);
        check("t6_re_rdata", l_rdata, l_data[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
